sbox_share_feeder: RTL



---
 rtl/sbox_share_feeder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sbox_share_feeder.sv
// Splits an unshared state into 2-share Boolean nibbles, one per cycle, for a 1-cycle TI S-box.
// Emits a result valid/index stream delayed one cycle so it lines up with the S-box outputs.
module sbox_share_feeder #(
  parameter int NIBBLES = 16,
  parameter int IDXW    = $clog2(NIBBLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] data_in,
  input  logic [3:0]           rnd_in,
  input  logic                 rnd_valid,
  output logic                 busy,
  output logic [1:0]           ina,
  output logic [1:0]           inb,
  output logic [1:0]           inc,
  output logic [1:0]           ind,
  output logic                 sh_valid,
  output logic [IDXW-1:0]      sh_idx,
  output logic                 res_valid,
  output logic [IDXW-1:0]      res_idx,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [4*NIBBLES-1:0]   r_shift;
  logic [4*NIBBLES-1:0]   w_shift_nxt;
  logic [IDXW-1:0]        r_idx;
  logic [IDXW-1:0]        w_idx_nxt;
  logic [1:0]             w_ina_nxt;
  logic [1:0]             w_inb_nxt;
  logic [1:0]             w_inc_nxt;
  logic [1:0]             w_ind_nxt;
  logic                   w_sh_valid_nxt;
  logic [IDXW-1:0]        w_sh_idx_nxt;
  logic                   w_done_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_idx_nxt      = r_idx;
    w_ina_nxt      = 2'b00;
    w_inb_nxt      = 2'b00;
    w_inc_nxt      = 2'b00;
    w_ind_nxt      = 2'b00;
    w_sh_valid_nxt = 1'b0;
    w_sh_idx_nxt   = sh_idx;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift_nxt = data_in;
          w_idx_nxt   = '0;
          w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        // Without fresh randomness nothing is emitted; the nibble waits for a mask.
        if (rnd_valid) begin
          w_ina_nxt      = {rnd_in[0], r_shift[0] ^ rnd_in[0]};
          w_inb_nxt      = {rnd_in[1], r_shift[1] ^ rnd_in[1]};
          w_inc_nxt      = {rnd_in[2], r_shift[2] ^ rnd_in[2]};
          w_ind_nxt      = {rnd_in[3], r_shift[3] ^ rnd_in[3]};
          w_sh_valid_nxt = 1'b1;
          w_sh_idx_nxt   = r_idx;
          w_shift_nxt    = r_shift >> 4;
          w_idx_nxt      = r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      ina       <= 2'b00;
      inb       <= 2'b00;
      inc       <= 2'b00;
      ind       <= 2'b00;
      sh_valid  <= 1'b0;
      sh_idx    <= '0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      done      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_idx     <= w_idx_nxt;
      busy      <= (w_state_nxt != S_IDLE);
      ina       <= w_ina_nxt;
      inb       <= w_inb_nxt;
      inc       <= w_inc_nxt;
      ind       <= w_ind_nxt;
      sh_valid  <= w_sh_valid_nxt;
      sh_idx    <= w_sh_idx_nxt;
      // S-box has one register stage, so results trail the shares by exactly one cycle.
      res_valid <= sh_valid;
      res_idx   <= sh_idx;
      done      <= w_done_nxt;
    end
  end

endmodule
